// File: rtl/bcd_seq_mult_pkg.sv
// Shared types and constants for the sequential packed-BCD multiplier.
package bcd_seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ADD   = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam int unsigned           DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0]    MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_seq_mult_if.sv
// Start/busy/done handshake and operand/result bus of the BCD multiplier.
interface bcd_seq_mult_if #(
  parameter int unsigned NDIGITS = 2
);
  logic                   start;
  logic [4*NDIGITS-1:0]   a;
  logic [4*NDIGITS-1:0]   b;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [8*NDIGITS-1:0]   product;

  modport master (output start, a, b, input busy, done, error, product);
  modport slave  (input start, a, b, output busy, done, error, product);
endinterface

// File: rtl/bcd_seq_mult_add_n.sv
// Combinational N-digit packed-BCD adder: ripple of per-digit decimal-corrected adders.
module bcd_add_n
  import bcd_seq_mult_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic [DIGIT_W*NDIGITS-1:0] i_x,
  input  logic [DIGIT_W*NDIGITS-1:0] i_y,
  output logic [DIGIT_W*NDIGITS-1:0] o_sum
);

  logic [NDIGITS:0] w_carry;

  assign w_carry[0] = 1'b0;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    logic [DIGIT_W:0] w_raw;

    assign w_raw = {1'b0, i_x[g*DIGIT_W +: DIGIT_W]}
                 + {1'b0, i_y[g*DIGIT_W +: DIGIT_W]}
                 + {{DIGIT_W{1'b0}}, w_carry[g]};
    // Sums above 9 skip the six unused codes and carry into the next digit
    assign w_carry[g+1] = (w_raw > 5'd9);
    assign o_sum[g*DIGIT_W +: DIGIT_W] =
      w_carry[g+1] ? DIGIT_W'(w_raw + 5'd6) : w_raw[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_seq_mult.sv
// Sequential NDIGITS x NDIGITS packed-BCD multiplier, MSD-first shift and repeated add.
// Optional: define BCD_MULT_ZSKIP_EN to finish at once when either valid operand is zero.
module bcd_seq_mult
  import bcd_seq_mult_pkg::*;
#(
  parameter int unsigned NDIGITS = 2
) (
  input  logic          clk,
  input  logic          reset,
  bcd_seq_mult_if.slave bus
);

  localparam int unsigned OPW  = DIGIT_W * NDIGITS;
  localparam int unsigned ACCW = 2 * OPW;

  state_t            r_state, w_state_nxt;
  logic [OPW-1:0]    r_a, r_b;
  logic [ACCW-1:0]   r_acc, w_acc_nxt, w_sum, r_product;
  logic [3:0]        r_idx, w_idx_nxt, r_cnt, w_cnt_nxt, w_bdig;
  logic              r_error, w_err_nxt, w_accept, w_bad;

  bcd_add_n #(.NDIGITS(2*NDIGITS)) u_add (
    .i_x   (r_acc),
    .i_y   ({{OPW{1'b0}}, r_a}),
    .o_sum (w_sum)
  );

  assign w_bdig   = DIGIT_W'(r_b >> {r_idx, 2'b00});
  assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_FIN);

  always_comb begin
    w_bad = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (bus.a[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT ||
          bus.b[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT)
        w_bad = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_error;
    case (r_state)
      // FIN behaves like IDLE so a start in the done cycle is accepted
      S_IDLE, S_FIN: begin
        w_state_nxt = S_IDLE;
        if (bus.start) begin
          w_acc_nxt = '0;
          w_cnt_nxt = '0;
          w_idx_nxt = 4'(NDIGITS - 1);
          w_err_nxt = w_bad;
          if (w_bad)
            w_state_nxt = S_FIN;
`ifdef BCD_MULT_ZSKIP_EN
          else if (bus.a == '0 || bus.b == '0)
            w_state_nxt = S_FIN;
`endif
          else
            w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_acc_nxt = {r_acc[ACCW-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
        w_cnt_nxt = w_bdig;
        if (w_bdig != '0) begin
          w_state_nxt = S_ADD;
        end else if (r_idx != '0) begin
          w_idx_nxt   = r_idx - 4'd1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_FIN;
        end
      end
      S_ADD: begin
        w_acc_nxt = w_sum;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          if (r_idx != '0) begin
            w_idx_nxt   = r_idx - 4'd1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_FIN;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Product is captured on entry to FIN so it is already valid while done is high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_error   <= 1'b0;
      r_product <= '0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_error <= w_err_nxt;
      if (w_accept) begin
        r_a <= bus.a;
        r_b <= bus.b;
      end
      if (w_state_nxt == S_FIN)
        r_product <= w_acc_nxt;
    end
  end

  assign bus.busy    = (r_state == S_SHIFT) || (r_state == S_ADD);
  assign bus.done    = (r_state == S_FIN);
  assign bus.error   = r_error;
  assign bus.product = r_product;

endmodule
